// File: rtl/steering_pkg.sv
// Shared constants for the multi-channel steering PWM block: register map,
// identification word, parameter defaults and the byte-lane write merge.
package steering_pkg;

    localparam logic [3:0] ADDR_ID       = 4'd0;
    localparam logic [3:0] ADDR_ENABLE   = 4'd1;
    localparam logic [3:0] ADDR_PRESCALE = 4'd2;
    localparam logic [3:0] ADDR_PERIOD   = 4'd3;
    localparam logic [3:0] ADDR_STEP     = 4'd4;
    localparam logic [3:0] ADDR_STATUS   = 4'd5;
    localparam logic [3:0] ADDR_TARGET0  = 4'd8;

    localparam logic [31:0] ID_VALUE = 32'hEA680004;

    localparam int NUM_CH_DEF       = 4;
    localparam int CNT_W_DEF        = 16;
    localparam int PRESCALE_RST_DEF = 49;
    localparam int PERIOD_RST_DEF   = 19999;
    localparam int WIDTH_RST_DEF    = 1500;

    // Replace only the byte lanes selected by be; other lanes keep old_val.
    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] wr_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? wr_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/steering_pwm_multi_channel.sv
// One servo channel: per-frame slew of the current width toward its target,
// and the registered width compare that forms the pulse.
module steering_channel
    import steering_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WIDTH_RST = WIDTH_RST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             boundary,
    input  logic             en_act,
    input  logic [CNT_W-1:0] step,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] frame_cnt,
    output logic             pwm,
    output logic             settled
);

    logic [CNT_W-1:0] cur_q, cur_d;
    logic [CNT_W-1:0] diff;
    logic [CNT_W-1:0] delta;
    logic             pwm_q, pwm_d;

    // Slew cur toward target once per frame; a disabled channel just follows target.
    always_comb begin
        cur_d = cur_q;
        diff  = (target >= cur_q) ? (target - cur_q) : (cur_q - target);
        delta = ((step == '0) || (step > diff)) ? diff : step;
        if (!en_act) begin
            cur_d = target;
        end else if (boundary) begin
            cur_d = (target >= cur_q) ? (cur_q + delta) : (cur_q - delta);
        end
        pwm_d = en_act && (frame_cnt < cur_q);
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q <= CNT_W'(WIDTH_RST);
            pwm_q <= 1'b0;
        end else begin
            cur_q <= cur_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm     = pwm_q;
    assign settled = (cur_q == target);

endmodule

// File: rtl/steering_pwm_multi.sv
// Multi-channel servo PWM generator on an Avalon-MM slave: bus registers,
// shared prescaler / frame counter, and frame-boundary shadow copies.
module steering_pwm_multi
    import steering_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int PRESCALE_RST = PRESCALE_RST_DEF,
    parameter int PERIOD_RST   = PERIOD_RST_DEF,
    parameter int WIDTH_RST    = WIDTH_RST_DEF
) (
    input  logic              csi_MCLK_clk,
    input  logic              rsi_MRST_reset,
    input  logic [3:0]        avs_ctrl_address,
    input  logic              avs_ctrl_write,
    input  logic              avs_ctrl_read,
    input  logic [31:0]       avs_ctrl_writedata,
    input  logic [3:0]        avs_ctrl_byteenable,
    output logic [31:0]       avs_ctrl_readdata,
    output logic              avs_ctrl_waitrequest,
    output logic [NUM_CH-1:0] pwm_out
);

    logic [NUM_CH-1:0] enable_q, enable_d;
    logic [CNT_W-1:0]  prescale_q, prescale_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]  target_q [NUM_CH];
    logic [CNT_W-1:0]  target_d [NUM_CH];
    logic [31:0]       readdata_q, readdata_d;

    logic [NUM_CH-1:0] en_act_q, en_act_d;
    logic [CNT_W-1:0]  prescale_act_q, prescale_act_d;
    logic [CNT_W-1:0]  period_act_q, period_act_d;
    logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [15:0]       frame_num_q, frame_num_d;

    logic [NUM_CH-1:0] settled;
    logic [31:0]       rd_val;
    logic [31:0]       wr_merged;
    logic              tick;
    logic              boundary;
    logic              unused_wr;

    // Read mux over the register map; unmapped words and absent channels read 0.
    always_comb begin
        rd_val = '0;
        case (avs_ctrl_address)
            ADDR_ID:       rd_val = ID_VALUE;
            ADDR_ENABLE:   rd_val = 32'(enable_q);
            ADDR_PRESCALE: rd_val = 32'(prescale_q);
            ADDR_PERIOD:   rd_val = 32'(period_q);
            ADDR_STEP:     rd_val = 32'(step_q);
            ADDR_STATUS:   rd_val = {frame_num_q, 16'(settled)};
            default:       rd_val = '0;
        endcase
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (avs_ctrl_address == 4'(ADDR_TARGET0 + ch)) begin
                rd_val = 32'(target_q[ch]);
            end
        end
    end

    // Byte-lane writes merge into the addressed register; a write suppresses a same-cycle read.
    always_comb begin
        enable_d   = enable_q;
        prescale_d = prescale_q;
        period_d   = period_q;
        step_d     = step_q;
        target_d   = target_q;
        readdata_d = readdata_q;
        wr_merged  = be_merge(rd_val, avs_ctrl_writedata, avs_ctrl_byteenable);
        if (avs_ctrl_write) begin
            case (avs_ctrl_address)
                ADDR_ENABLE:   enable_d   = wr_merged[NUM_CH-1:0];
                ADDR_PRESCALE: prescale_d = wr_merged[CNT_W-1:0];
                ADDR_PERIOD:   period_d   = wr_merged[CNT_W-1:0];
                ADDR_STEP:     step_d     = wr_merged[CNT_W-1:0];
                default:       ;
            endcase
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (avs_ctrl_address == 4'(ADDR_TARGET0 + ch)) begin
                    target_d[ch] = wr_merged[CNT_W-1:0];
                end
            end
        end else if (avs_ctrl_read) begin
            readdata_d = rd_val;
        end
    end

    assign unused_wr = ^wr_merged;

    // Timebase: prescaler tick, frame counter, and shadow reload at the frame boundary.
    always_comb begin
        tick           = (pre_cnt_q == prescale_act_q);
        boundary       = tick && (frame_cnt_q == period_act_q);
        pre_cnt_d      = tick ? '0 : (pre_cnt_q + 1'b1);
        frame_cnt_d    = frame_cnt_q;
        prescale_act_d = prescale_act_q;
        period_act_d   = period_act_q;
        en_act_d       = en_act_q;
        frame_num_d    = frame_num_q;
        if (tick) begin
            frame_cnt_d = boundary ? '0 : (frame_cnt_q + 1'b1);
        end
        if (boundary) begin
            prescale_act_d = prescale_q;
            period_act_d   = period_q;
            en_act_d       = enable_q;
            frame_num_d    = frame_num_q + 16'd1;
        end
    end

    // All top-level state, returned to power-on values by the synchronous reset.
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            enable_q       <= '0;
            prescale_q     <= CNT_W'(PRESCALE_RST);
            period_q       <= CNT_W'(PERIOD_RST);
            step_q         <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) target_q[ch] <= CNT_W'(WIDTH_RST);
            readdata_q     <= '0;
            en_act_q       <= '0;
            prescale_act_q <= CNT_W'(PRESCALE_RST);
            period_act_q   <= CNT_W'(PERIOD_RST);
            pre_cnt_q      <= '0;
            frame_cnt_q    <= '0;
            frame_num_q    <= '0;
        end else begin
            enable_q       <= enable_d;
            prescale_q     <= prescale_d;
            period_q       <= period_d;
            step_q         <= step_d;
            target_q       <= target_d;
            readdata_q     <= readdata_d;
            en_act_q       <= en_act_d;
            prescale_act_q <= prescale_act_d;
            period_act_q   <= period_act_d;
            pre_cnt_q      <= pre_cnt_d;
            frame_cnt_q    <= frame_cnt_d;
            frame_num_q    <= frame_num_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        steering_channel #(
            .CNT_W     (CNT_W),
            .WIDTH_RST (WIDTH_RST)
        ) u_ch (
            .clk       (csi_MCLK_clk),
            .rst       (rsi_MRST_reset),
            .boundary  (boundary),
            .en_act    (en_act_q[g]),
            .step      (step_q),
            .target    (target_q[g]),
            .frame_cnt (frame_cnt_q),
            .pwm       (pwm_out[g]),
            .settled   (settled[g])
        );
    end

    assign avs_ctrl_readdata    = readdata_q;
    assign avs_ctrl_waitrequest = 1'b0;

endmodule

// File: tb/tb_steering_pwm_multi.sv
// Directed bench for steering_pwm_multi. The reset prescaler is overridden to
// 0 so the default 20000-tick frame lasts 20000 clocks.
module tb_steering_pwm_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        addr;
    logic              wr;
    logic              rd;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic [31:0]       rdata;
    logic              waitreq;
    logic [NUM_CH-1:0] pwm_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    steering_pwm_multi #(
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .PRESCALE_RST (0),
        .PERIOD_RST   (19999),
        .WIDTH_RST    (1500)
    ) dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_ctrl_address     (addr),
        .avs_ctrl_write       (wr),
        .avs_ctrl_read        (rd),
        .avs_ctrl_writedata   (wdata),
        .avs_ctrl_byteenable  (be),
        .avs_ctrl_readdata    (rdata),
        .avs_ctrl_waitrequest (waitreq),
        .pwm_out              (pwm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; wr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic wait_pwm0(input logic lvl, input int limit, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            if (pwm_out[0] === lvl) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Waits for the next rising edge on channel 0, then counts its high clocks.
    task automatic measure_width(output int w, output bit ok);
        bit ok1, ok2;
        w = 0;
        wait_pwm0(1'b0, 25000, ok1);
        wait_pwm0(1'b1, 25000, ok2);
        ok = ok1 && ok2;
        while (ok && pwm_out[0] === 1'b1 && w < 100) begin
            w++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (pwm_out !== 4'b0000) begin errors++; $display("FAIL reset_pwm got %h want 0", pwm_out); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", rdata); end
        checks++;
        if (waitreq !== 1'b0) begin errors++; $display("FAIL waitrequest got %b want 0", waitreq); end
        bus_read(4'd0, d);
        checks++;
        if (d !== 32'hEA680004) begin errors++; $display("FAIL read_id got %h want ea680004", d); end
        bus_read(4'd3, d);
        checks++;
        if (d !== 32'd19999) begin errors++; $display("FAIL read_period got %0d want 19999", d); end
        bus_read(4'd8, d);
        checks++;
        if (d !== 32'd1500) begin errors++; $display("FAIL read_target0 got %0d want 1500", d); end
        bus_read(4'd1, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL read_enable got %h want 0", d); end
        bus_read(4'd5, d);
        checks++;
        if (d !== 32'h0000000F) begin errors++; $display("FAIL read_status got %h want 0000000f", d); end
        bus_read(4'd6, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL read_unmapped got %h want 0", d); end
        bus_read(4'd12, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL read_absent_ch got %h want 0", d); end
        checks++;
        if (pwm_out !== 4'b0000) begin errors++; $display("FAIL reset_pwm_idle got %h want 0", pwm_out); end
    endtask

    task automatic test_basic_pwm;
        bit ok;
        logic exp;
        bus_write(4'd3, 32'd9, 4'hF);
        bus_write(4'd8, 32'd3, 4'hF);
        bus_write(4'd1, 32'd1, 4'hF);
        wait_pwm0(1'b1, 25000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_rise got timeout want pwm0 high"); end
        for (int i = 0; i < 30; i++) begin
            exp = ((i % 10) < 3);
            checks++;
            if (pwm_out[0] !== exp) begin
                errors++; $display("FAIL basic_pattern[%0d] got %b want %b", i, pwm_out[0], exp);
            end
            checks++;
            if (pwm_out[3:1] !== 3'b000) begin
                errors++; $display("FAIL basic_others[%0d] got %b want 000", i, pwm_out[3:1]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_slew;
        bit ok;
        int w;
        logic [31:0] d;
        int exp_w [3] = '{5, 7, 8};
        logic exp_s [3] = '{1'b0, 1'b0, 1'b1};
        wait_pwm0(1'b0, 50, ok);
        wait_pwm0(1'b1, 50, ok);
        bus_write(4'd4, 32'd2, 4'hF);
        bus_write(4'd8, 32'd8, 4'hF);
        for (int f = 0; f < 3; f++) begin
            measure_width(w, ok);
            checks++;
            if (!ok || w != exp_w[f]) begin
                errors++; $display("FAIL slew_width[%0d] got %0d want %0d", f, w, exp_w[f]);
            end
            bus_read(4'd5, d);
            checks++;
            if (d[0] !== exp_s[f]) begin
                errors++; $display("FAIL slew_settled[%0d] got %b want %b", f, d[0], exp_s[f]);
            end
        end
    endtask

    task automatic test_extremes;
        bus_write(4'd4, 32'd0, 4'hF);
        bus_write(4'd8, 32'd0, 4'hF);
        repeat (15) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (pwm_out !== 4'b0000) begin
                errors++; $display("FAIL width0_low[%0d] got %h want 0", i, pwm_out);
            end
            @(negedge clk);
        end
        bus_write(4'd8, 32'd12, 4'hF);
        repeat (15) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            checks++;
            if (pwm_out !== 4'b0001) begin
                errors++; $display("FAIL width12_high[%0d] got %h want 1", i, pwm_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_byteenable;
        logic [31:0] d;
        bus_write(4'd9, 32'h0000FFFF, 4'b0001);
        bus_read(4'd9, d);
        checks++;
        if (d !== 32'h000005FF) begin errors++; $display("FAIL be_lane0 got %h want 000005ff", d); end
        bus_write(4'd10, 32'h0000AB00, 4'b0010);
        bus_read(4'd10, d);
        checks++;
        if (d !== 32'h0000ABDC) begin errors++; $display("FAIL be_lane1 got %h want 0000abdc", d); end
        bus_write(4'd0, 32'h12345678, 4'hF);
        bus_read(4'd0, d);
        checks++;
        if (d !== 32'hEA680004) begin errors++; $display("FAIL id_write_ignored got %h want ea680004", d); end
        // Simultaneous read and write of TARGET3: write lands, readdata keeps the ID.
        addr = 4'd11; wdata = 32'h00000077; be = 4'hF; wr = 1'b1; rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; be = 4'h0;
        checks++;
        if (rdata !== 32'hEA680004) begin errors++; $display("FAIL rw_collision got %h want ea680004", rdata); end
        bus_read(4'd11, d);
        checks++;
        if (d !== 32'h00000077) begin errors++; $display("FAIL rw_write_won got %h want 00000077", d); end
    endtask

    task automatic test_midframe_reset;
        bit ok;
        int t0;
        int w;
        logic [31:0] d;
        bus_read(4'd0, d);
        wait_pwm0(1'b1, 50, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pre_reset_high got timeout want pwm0 high"); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        t0 = cyc;
        checks++;
        if (pwm_out !== 4'b0000) begin errors++; $display("FAIL midreset_pwm got %h want 0", pwm_out); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL midreset_readdata got %h want 0", rdata); end
        bus_read(4'd3, d);
        checks++;
        if (d !== 32'd19999) begin errors++; $display("FAIL midreset_period got %0d want 19999", d); end
        bus_read(4'd8, d);
        checks++;
        if (d !== 32'd1500) begin errors++; $display("FAIL midreset_target0 got %0d want 1500", d); end
        bus_read(4'd4, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL midreset_step got %0d want 0", d); end
        bus_read(4'd5, d);
        checks++;
        if (d !== 32'h0000000F) begin errors++; $display("FAIL midreset_status got %h want 0000000f", d); end
        bus_write(4'd1, 32'd1, 4'hF);
        wait_pwm0(1'b1, 25000, ok);
        checks++;
        if (!ok || (cyc - t0) != 20001) begin
            errors++; $display("FAIL first_frame_len got %0d want 20001", cyc - t0);
        end
        w = 0;
        while (pwm_out[0] === 1'b1 && w < 2000) begin
            w++;
            @(negedge clk);
        end
        checks++;
        if (w != 1500) begin errors++; $display("FAIL default_width got %0d want 1500", w); end
    endtask

    initial begin
        rst = 1'b1; addr = '0; wr = 1'b0; rd = 1'b0; wdata = '0; be = '0;
        @(negedge clk);
        test_reset();
        test_basic_pwm();
        test_slew();
        test_extremes();
        test_byteenable();
        test_midframe_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/steering_pwm_multi.md
# steering_pwm_multi

Multi-channel servo/steering PWM generator. It is the parametrised successor to the single-channel steering driver and sits on the Qsys Avalon-MM control bus. It drives NUM_CH independent servo outputs from one clock, with programmable prescaler and frame period, per-channel pulse width, enable mask, and per-frame slew limiting. All register changes take effect at frame boundaries, so no runt or glitch pulses reach the servos.

## Interface
Parameters:
- NUM_CH, 4: channel count, 1..8
- CNT_W, 16: width of prescaler, period and pulse-width counters
- PRESCALE_RST, 49: reset prescaler; 50 MHz clock gives a 1 µs tick
- PERIOD_RST, 19999: reset frame length in ticks minus 1 (20 ms)
- WIDTH_RST, 1500: reset target/current width in ticks (1.5 ms, centre)

Ports (one clock; reset is synchronous and active-high):
- csi_MCLK_clk  in  1  sole clock
- rsi_MRST_reset  in  1  synchronous active-high reset
- avs_ctrl_address  in  4  word address
- avs_ctrl_write  in  1  write strobe
- avs_ctrl_read  in  1  read strobe
- avs_ctrl_writedata  in  32  write data
- avs_ctrl_byteenable  in  4  byte lanes for writes
- avs_ctrl_readdata  out  32  registered read data, read latency 1
- avs_ctrl_waitrequest  out  1  tied 0
- pwm_out  out  NUM_CH  servo pulse outputs, registered

## Operation
Register map (word address; R/W unless stated):
- 0 ID, RO: 32'hEA680004
- 1 ENABLE: [NUM_CH-1:0] channel enable mask
- 2 PRESCALE: [CNT_W-1:0]; tick every PRESCALE+1 clocks
- 3 PERIOD: [CNT_W-1:0]; frame = PERIOD+1 ticks
- 4 STEP: [CNT_W-1:0]; max width change per frame, 0 = unlimited (jump)
- 5 STATUS, RO: [NUM_CH-1:0] settled (current == target); [31:16] frame counter, wraps at 0xFFFF
- 8+ch TARGET[ch]: [CNT_W-1:0] target pulse width in ticks

Register rules:
- Unused bits read 0.
- Unmapped addresses, and channels ≥ NUM_CH, read 0; writes to them are ignored.
- Writes honour byteenable per byte lane. Writes to RO registers are ignored.
- Write and read in the same cycle: write wins, readdata holds its previous value.

Counters:
- Prescaler pre_cnt counts 0..PRESCALE_act. tick = (pre_cnt == PRESCALE_act).
- frame_cnt advances on tick and wraps from PERIOD_act to 0.
- Frame boundary = tick && frame_cnt == PERIOD_act.

At each frame boundary:
- PRESCALE_act ← PRESCALE, PERIOD_act ← PERIOD, EN_act ← ENABLE.
- For each enabled channel, cur[ch] moves toward TARGET[ch] by min(STEP, |diff|). There is no overshoot; arithmetic is unsigned CNT_W and saturating.
- STATUS frame counter increments.

Channel behaviour:
- Disabled channel (EN_act=0): cur[ch] ← TARGET[ch] every cycle; output 0.
- Output: pwm_out[ch] ← EN_act[ch] && (frame_cnt < cur[ch]).
- cur = 0 gives constant low. cur ≥ PERIOD_act+1 gives constant high (100%).

## Timing
- Reset (synchronous, any time, including mid-frame): on the next edge pwm_out=0, readdata=0, pre_cnt=frame_cnt=0, frame counter=0, ENABLE=EN_act=0, STEP=0, PRESCALE/PERIOD and their active copies = *_RST, TARGET/cur = WIDTH_RST.
- Read: readdata is valid on the cycle after avs_ctrl_read is sampled high; the value holds until the next read.
- Write: register updates on the sampled edge. ENABLE/PRESCALE/PERIOD/STEP/TARGET affect outputs only from the next frame boundary.
- pwm_out lags the counter by 1 clock. The rising edge occurs 1 clock after frame_cnt becomes 0.
- Frame length in clocks = (PRESCALE_act+1)·(PERIOD_act+1).
- Slew is applied once per frame, never mid-frame. All channels rise together.

## Structure
- Package steering_pkg holds:
  - register address localparams (ADDR_ID..ADDR_TARGET0)
  - ID constant 32'hEA680004
  - default parameter values
- Sub-module steering_channel (slew update plus compare, one per channel) is generated NUM_CH times.
- The top level holds the bus registers, prescaler, frame counter and shadow logic.

## Test plan
- Reset, then read addresses 0/3/8: readdata 1 cycle later = 32'hEA680004 / 19999 / 1500; pwm_out = 0.
- PRESCALE=0, PERIOD=9, TARGET0=3, ENABLE=1: after the next boundary, pwm_out[0] is high 3 clocks, low 7, repeating every 10 clocks; other channels stay 0.
- STEP=2, cur0=3, write TARGET0=8: per-frame widths 5, 7, 8; STATUS[0]=0 until the frame where the width reaches 8, then 1.
- TARGET0=0 gives pwm_out[0] constant low. TARGET0=12 with PERIOD=9 gives constant high across ≥3 frames.
- Write 0x0000FFFF to TARGET1 with byteenable 4'b0001, starting from 1500 (0x05DC): TARGET1 reads 0x05FF. Write to address 0 leaves ID unchanged.
- Assert reset for 1 cycle mid-pulse: pwm_out=0 on the next edge, all registers at defaults, and the first frame after reset has default length.
